frame_arbiter: RTL and testbench

FRAME_ARBITER -- requirements
Module: frame_arbiter

---
 rtl/frame_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_frame_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_arbiter.sv
// frame_arbiter: round-robin arbiter that forwards one source's byte frame to
// a framer queue, waits for the framer's transfer-end pulse, then holds off for
// a guard interval before arbitrating again.
module frame_arbiter #(
    parameter int MAX_LEN       = 20,
    parameter int START_TIMEOUT = 16,
    parameter int GUARD_CYCLES  = 17,
    parameter int TX_TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  req,
    input  logic [31:0] src_data,
    input  logic [3:0]  src_valid,
    output logic [3:0]  grant,
    output logic [7:0]  fifo_din,
    output logic        fifo_din_valid,
    input  logic        fifo_indicator,
    output logic        busy,
    output logic        frame_done,
    output logic [4:0]  frame_len,
    output logic        err_overflow,
    output logic        err_timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GRANTED = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_WAIT_TX = 3'd3;
    localparam logic [2:0] S_GUARD   = 3'd4;

    localparam logic [9:0] C_MAX_LEN   = 10'(MAX_LEN);
    localparam logic [9:0] C_START_END = 10'(START_TIMEOUT - 1);
    localparam logic [9:0] C_GUARD_END = 10'(GUARD_CYCLES - 1);
    localparam logic [9:0] C_TX_END    = 10'(TX_TIMEOUT - 1);

    logic [2:0] r_state;
    logic [3:0] r_grant;
    logic [1:0] r_gidx;
    logic [1:0] r_last;
    logic [9:0] r_count;
    logic [9:0] r_wait;
    logic [9:0] r_guard;
    logic [4:0] r_frame_len;
    logic       r_frame_done;
    logic       r_err_ovf;
    logic       r_err_tmo;

    logic       w_found;
    logic [1:0] w_sel;
    logic [1:0] w_idx;
    logic       w_src_valid;
    logic       w_fwd;
    logic [7:0] w_din;

    // Round-robin pick: first requester starting one past the last grant
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_last;
        w_idx   = r_last;
        for (int unsigned i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Zero-latency byte path from the granted source to the framer
    always_comb begin
        w_src_valid = src_valid[r_gidx];
        w_fwd       = w_src_valid && ((r_state == S_GRANTED) || (r_state == S_LOAD))
                      && (r_count < C_MAX_LEN);
        w_din       = '0;
        if (r_grant != '0) begin
            w_din = src_data[{r_gidx, 3'b000} +: 8];
        end
    end

    // Frame FSM: grant, load, wait for framer, guard; counters cleared on each state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last       <= 2'd3;
            r_count      <= '0;
            r_wait       <= '0;
            r_guard      <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_tmo    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_tmo    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= 4'b0001 << w_sel;
                        r_gidx  <= w_sel;
                        r_last  <= w_sel;
                        r_state <= S_GRANTED;
                        r_count <= '0;
                        r_wait  <= '0;
                        r_guard <= '0;
                    end
                end
                S_GRANTED: begin
                    if (w_fwd) begin
                        r_count <= 10'd1;
                        r_wait  <= '0;
                        r_guard <= '0;
                        r_state <= S_LOAD;
                    end else if (!req[r_gidx]) begin
                        r_grant <= '0;
                        r_count <= '0;
                        r_wait  <= '0;
                        r_guard <= '0;
                        r_state <= S_IDLE;
                    end else if (r_wait == C_START_END) begin
                        r_err_tmo <= 1'b1;
                        r_grant   <= '0;
                        r_count   <= '0;
                        r_wait    <= '0;
                        r_guard   <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + 10'd1;
                    end
                end
                S_LOAD: begin
                    if (!w_src_valid || (r_count == C_MAX_LEN)) begin
                        // only reachable with valid high when the frame is already full
                        r_err_ovf   <= w_src_valid;
                        r_grant     <= '0;
                        r_frame_len <= r_count[4:0];
                        r_count     <= '0;
                        r_wait      <= '0;
                        r_guard     <= '0;
                        r_state     <= S_WAIT_TX;
                    end else begin
                        r_count <= r_count + 10'd1;
                    end
                end
                S_WAIT_TX: begin
                    if (fifo_indicator) begin
                        r_frame_done <= 1'b1;
                        r_count      <= '0;
                        r_wait       <= '0;
                        r_guard      <= '0;
                        r_state      <= S_GUARD;
                    end else if (r_wait == C_TX_END) begin
                        r_err_tmo <= 1'b1;
                        r_count   <= '0;
                        r_wait    <= '0;
                        r_guard   <= '0;
                        r_state   <= S_GUARD;
                    end else begin
                        r_wait <= r_wait + 10'd1;
                    end
                end
                S_GUARD: begin
                    if (r_guard == C_GUARD_END) begin
                        r_count <= '0;
                        r_wait  <= '0;
                        r_guard <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_guard <= r_guard + 10'd1;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant          = r_grant;
    assign fifo_din       = w_din;
    assign fifo_din_valid = w_fwd;
    assign busy           = (r_state != S_IDLE);
    assign frame_done     = r_frame_done;
    assign frame_len      = r_frame_len;
    assign err_overflow   = r_err_ovf;
    assign err_timeout    = r_err_tmo;

endmodule

// File: tb/tb_frame_arbiter.sv
// Bench for frame_arbiter: directed scenarios plus randomized frames checked
// against a transaction-level model of grant order and frame contents.
module tb_frame_arbiter;

    localparam int MAXL = 20;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] src_data;
    logic [3:0]  src_valid;
    logic [3:0]  grant;
    logic [7:0]  fifo_din;
    logic        fifo_din_valid;
    logic        fifo_indicator;
    logic        busy;
    logic        frame_done;
    logic [4:0]  frame_len;
    logic        err_overflow;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;
    int ovf_cnt = 0;
    int done_cnt = 0;
    int tmo_cnt = 0;
    int m_last;
    logic [7:0] got_q[$];
    logic [7:0] tx_bytes [0:31];

    frame_arbiter #(
        .MAX_LEN(20),
        .START_TIMEOUT(16),
        .GUARD_CYCLES(17),
        .TX_TIMEOUT(1023)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .src_data(src_data),
        .src_valid(src_valid),
        .grant(grant),
        .fifo_din(fifo_din),
        .fifo_din_valid(fifo_din_valid),
        .fifo_indicator(fifo_indicator),
        .busy(busy),
        .frame_done(frame_done),
        .frame_len(frame_len),
        .err_overflow(err_overflow),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Observe the framer side and pulse outputs; grant must never be multi-hot
    always @(negedge clk) begin
        if (fifo_din_valid) got_q.push_back(fifo_din);
        if (err_overflow) ovf_cnt++;
        if (frame_done) done_cnt++;
        if (err_timeout) tmo_cnt++;
        if (reset_n) begin
            checks++;
            if ($countones(grant) > 1) begin
                errors++;
                $display("FAIL grant_onehot: got %b required at most one bit", grant);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Round-robin rule: first requester searching upward from last+1, wrapping
    function automatic int rr_pick(input logic [3:0] mask, input int last);
        for (int i = 1; i <= 4; i++) begin
            if (mask[(last + i) % 4]) return (last + i) % 4;
        end
        return -1;
    endfunction

    function automatic int oh_idx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return 0;
    endfunction

    function automatic int byte_mm(input int start, input int n);
        int m = 0;
        for (int j = 0; j < n; j++) begin
            if (start + j >= got_q.size()) m++;
            else if (got_q[start + j] !== tx_bytes[j]) m++;
        end
        return m;
    endfunction

    function automatic int min_len(input int n);
        return (n > MAXL) ? MAXL : n;
    endfunction

    // Drives one frame from whichever source is granted, then the framer pulse
    task automatic do_frame(input int n, input int dly, output logic [3:0] g_seen,
                            output int nb_start, output logic [4:0] flen, output int ovf,
                            output int dn, output int guard_cyc, output int leak, output bit ok);
        int w;
        int s;
        int o0;
        int d0;
        ok = 1'b1; leak = 0; guard_cyc = 0; dn = 0; ovf = 0; flen = '0; g_seen = '0;
        o0 = ovf_cnt; d0 = done_cnt; nb_start = got_q.size();
        w = 0;
        while (grant == '0 && w < 10) begin @(negedge clk); w++; end
        if (grant == '0) begin ok = 1'b0; return; end
        g_seen = grant;
        s = oh_idx(grant);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            src_data[8*s +: 8] = tx_bytes[k];
            src_valid[s] = 1'b1;
            if (k == 1) req[s] = 1'b0;
        end
        @(posedge clk); #1;
        src_valid[s] = 1'b0;
        req[s] = 1'b0;
        w = 0;
        while (grant != '0 && w < 5) begin @(negedge clk); w++; end
        if (grant != '0) begin ok = 1'b0; return; end
        repeat (dly) @(posedge clk);
        @(posedge clk); #1 fifo_indicator = 1'b1;
        @(posedge clk); #1 fifo_indicator = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (!frame_done && w < 50);
        if (!frame_done) begin ok = 1'b0; return; end
        while (busy && guard_cyc < 100) begin
            @(negedge clk);
            guard_cyc++;
            if (busy && grant != '0) leak++;
        end
        flen = frame_len;
        ovf = ovf_cnt - o0;
        dn = done_cnt - d0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = '0; src_data = '0; src_valid = '0; fifo_indicator = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, busy, fifo_din_valid, fifo_din, frame_done, frame_len, err_overflow, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got grant=%b busy=%b vld=%b din=%h done=%b len=%0d ovf=%b tmo=%b required all 0",
                     grant, busy, fifo_din_valid, fifo_din, frame_done, frame_len, err_overflow, err_timeout);
        end
        #1 reset_n = 1'b1;
        m_last = 3;
        repeat (2) @(negedge clk);
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got grant=%b busy=%b required 0000/0", grant, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g; int nb; logic [4:0] fl; int ov, dn, gc, lk; bit ok; int e;
        req = 4'b0101;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) tx_bytes[k] = 8'(8'h10 * (r + 1) + k);
            e = rr_pick(req, m_last);
            do_frame(4, 5, g, nb, fl, ov, dn, gc, lk, ok);
            m_last = e;
            checks++;
            if (!ok || g !== (4'b0001 << e)) begin
                errors++;
                $display("FAIL rr_grant_%0d: got %b ok=%0d required %b", r, g, ok, 4'b0001 << e);
            end
            checks++;
            if (dn !== 1 || fl !== 5'd4 || byte_mm(nb, 4) !== 0 || lk !== 0) begin
                errors++;
                $display("FAIL rr_frame_%0d: got done=%0d len=%0d bytemm=%0d leak=%0d required 1/4/0/0",
                         r, dn, fl, byte_mm(nb, 4), lk);
            end
        end
    endtask

    task automatic test_basic();
        logic [3:0] g; int nb; logic [4:0] fl; int ov, dn, gc, lk; bit ok;
        tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'hB2; tx_bytes[2] = 8'hC3;
        req = 4'b0010;
        do_frame(3, 200, g, nb, fl, ov, dn, gc, lk, ok);
        m_last = 1;
        checks++;
        if (!ok || g !== 4'b0010) begin
            errors++; $display("FAIL basic_grant: got %b ok=%0d required 0010", g, ok);
        end
        checks++;
        if (got_q.size() - nb !== 3 || byte_mm(nb, 3) !== 0) begin
            errors++; $display("FAIL basic_bytes: got count=%0d mm=%0d required 3/0", got_q.size() - nb, byte_mm(nb, 3));
        end
        checks++;
        if (dn !== 1 || fl !== 5'd3) begin
            errors++; $display("FAIL basic_done: got done=%0d len=%0d required 1/3", dn, fl);
        end
        checks++;
        if (gc !== 17 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_guard: got %0d cycles busy=%b required 17/0", gc, busy);
        end
    endtask

    task automatic test_overflow(input int n, input int src);
        logic [3:0] g; int nb; logic [4:0] fl; int ov, dn, gc, lk; bit ok;
        for (int k = 0; k < n; k++) tx_bytes[k] = 8'($urandom);
        req = 4'b0001 << src;
        do_frame(n, 3, g, nb, fl, ov, dn, gc, lk, ok);
        m_last = src;
        checks++;
        if (!ok || g !== (4'b0001 << src)) begin
            errors++; $display("FAIL len%0d_grant: got %b ok=%0d required %b", n, g, ok, 4'b0001 << src);
        end
        checks++;
        if (got_q.size() - nb !== min_len(n) || byte_mm(nb, min_len(n)) !== 0) begin
            errors++; $display("FAIL len%0d_bytes: got count=%0d mm=%0d required %0d/0",
                               n, got_q.size() - nb, byte_mm(nb, min_len(n)), min_len(n));
        end
        checks++;
        if (ov !== ((n > MAXL) ? 1 : 0) || fl !== 5'(min_len(n)) || dn !== 1) begin
            errors++; $display("FAIL len%0d_status: got ovf=%0d len=%0d done=%0d required %0d/%0d/1",
                               n, ov, fl, dn, (n > MAXL) ? 1 : 0, min_len(n));
        end
    endtask

    task automatic test_start_timeout();
        int w; int cyc; int t0;
        req = 4'b1000;
        t0 = tmo_cnt;
        w = 0;
        do begin @(negedge clk); w++; end while (grant == '0 && w < 10);
        m_last = 3;
        checks++;
        if (grant !== 4'b1000) begin
            errors++; $display("FAIL st_grant: got %b required 1000", grant);
        end
        cyc = 0;
        while (!err_timeout && cyc < 40) begin @(negedge clk); cyc++; end
        req = '0;
        checks++;
        if (cyc !== 16 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++; $display("FAIL st_timeout: got %0d cycles grant=%b busy=%b required 16/0000/0", cyc, grant, busy);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (tmo_cnt - t0 !== 1 || grant !== 4'b0000) begin
            errors++; $display("FAIL st_pulse: got %0d pulses grant=%b required 1/0000", tmo_cnt - t0, grant);
        end
    endtask

    task automatic test_tx_timeout();
        int w; int cyc; int d0; int t0;
        req = 4'b0001;
        d0 = done_cnt; t0 = tmo_cnt;
        w = 0;
        do begin @(negedge clk); w++; end while (grant == '0 && w < 10);
        m_last = 0;
        checks++;
        if (grant !== 4'b0001) begin
            errors++; $display("FAIL tx_grant: got %b required 0001", grant);
        end
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1 src_data[7:0] = 8'(8'h55 + k); src_valid[0] = 1'b1;
        end
        @(posedge clk); #1 src_valid[0] = 1'b0; req[0] = 1'b0;
        w = 0;
        do begin @(negedge clk); w++; end while (grant != '0 && w < 5);
        cyc = 0;
        while (!err_timeout && cyc < 1100) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc !== 1023 || busy !== 1'b1) begin
            errors++; $display("FAIL tx_timeout: got %0d cycles busy=%b required 1023/1", cyc, busy);
        end
        cyc = 0;
        while (busy && cyc < 100) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc !== 17 || done_cnt !== d0 || tmo_cnt - t0 !== 1 || frame_len !== 5'd2) begin
            errors++; $display("FAIL tx_guard: got guard=%0d done=%0d tmo=%0d len=%0d required 17/0/1/2",
                               cyc, done_cnt - d0, tmo_cnt - t0, frame_len);
        end
    endtask

    task automatic test_reset_midframe();
        int w;
        logic [3:0] g; int nb; logic [4:0] fl; int ov, dn, gc, lk; bit ok;
        req = 4'b0001;
        w = 0;
        do begin @(negedge clk); w++; end while (grant == '0 && w < 10);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 src_data[7:0] = 8'(8'h30 + k); src_valid[0] = 1'b1;
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({grant, busy, fifo_din_valid, fifo_din, frame_done, frame_len, err_overflow, err_timeout} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got grant=%b busy=%b vld=%b din=%h done=%b len=%0d ovf=%b tmo=%b required all 0",
                     grant, busy, fifo_din_valid, fifo_din, frame_done, frame_len, err_overflow, err_timeout);
        end
        src_valid = '0; req = '0;
        @(negedge clk); #1 reset_n = 1'b1;
        m_last = 3;
        // Two requesters: a restored last_grant of 3 must favour source 0
        req = 4'b0011;
        for (int r = 0; r < 2; r++) begin
            tx_bytes[0] = 8'h77; tx_bytes[1] = 8'h88;
            do_frame(2, 1, g, nb, fl, ov, dn, gc, lk, ok);
            checks++;
            if (!ok || g !== (4'b0001 << r) || dn !== 1 || fl !== 5'd2) begin
                errors++; $display("FAIL midreset_frame_%0d: got grant=%b ok=%0d done=%0d len=%0d required %b/1/1/2",
                                   r, g, ok, dn, fl, 4'b0001 << r);
            end
        end
        m_last = 1;
    endtask

    task automatic test_random();
        logic [3:0] pending; logic [3:0] g; int nb; logic [4:0] fl; int ov, dn, gc, lk; bit ok;
        int e; int n; int dly;
        for (int round = 0; round < 6; round++) begin
            pending = 4'($urandom_range(1, 15));
            req = pending;
            while (pending != '0) begin
                n = $urandom_range(1, 24);
                dly = $urandom_range(0, 40);
                for (int k = 0; k < n; k++) tx_bytes[k] = 8'($urandom);
                e = rr_pick(pending, m_last);
                do_frame(n, dly, g, nb, fl, ov, dn, gc, lk, ok);
                m_last = e;
                pending[e] = 1'b0;
                checks++;
                if (!ok || g !== (4'b0001 << e)) begin
                    errors++; $display("FAIL rand_grant r%0d: got %b ok=%0d required %b", round, g, ok, 4'b0001 << e);
                end
                checks++;
                if (got_q.size() - nb !== min_len(n) || byte_mm(nb, min_len(n)) !== 0) begin
                    errors++; $display("FAIL rand_bytes r%0d n=%0d: got count=%0d mm=%0d required %0d/0",
                                       round, n, got_q.size() - nb, byte_mm(nb, min_len(n)), min_len(n));
                end
                checks++;
                if (fl !== 5'(min_len(n)) || ov !== ((n > MAXL) ? 1 : 0) || dn !== 1 || gc !== 17 || lk !== 0) begin
                    errors++; $display("FAIL rand_status r%0d n=%0d: got len=%0d ovf=%0d done=%0d guard=%0d leak=%0d required %0d/%0d/1/17/0",
                                       round, n, fl, ov, dn, gc, lk, min_len(n), (n > MAXL) ? 1 : 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_basic();
        test_overflow(25, 2);
        test_overflow(20, 0);
        test_start_timeout();
        test_tx_timeout();
        test_reset_midframe();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
